// File: rtl/rf_wport_sched.sv
// Register-file write-port arbiter (WB vs long-latency unit) with a busy scoreboard for LLU destinations.
// Optional same-cycle RAW bypass on LLU write-back when RF_WPORT_BYPASS_EN is defined.
module rf_wport_sched #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int MAX_STARVE     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [XLEN-1:0]           wb_data,
    output logic                      wb_ready,
    input  logic                      llu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] llu_rd,
    input  logic [XLEN-1:0]           llu_data,
    output logic                      llu_ready,
    input  logic                      iss_valid,
    input  logic                      iss_long,
    input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
    input  logic [REG_ADDR_WIDTH-1:0] iss_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] iss_rs2,
    output logic                      iss_stall,
    output logic                      rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_rd,
    output logic [XLEN-1:0]           rf_write_data,
    output logic [NUM_REGS-1:0]       busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [3:0]          starve_cnt;
    logic                starved;
    logic                wb_gnt;
    logic                llu_gnt;
    logic                rs1_busy, rs2_busy, rd_busy;
    logic                rs1_byp, rs2_byp;
    logic                set_en;

    assign starved = (starve_cnt >= 4'(MAX_STARVE));
    assign llu_gnt = !reset && llu_valid && (!wb_valid || starved);
    assign wb_gnt  = !reset && wb_valid && !llu_gnt;

    // Idle requesters report ready so they can present a result without a bubble.
    assign wb_ready  = !reset && (wb_gnt || !wb_valid);
    assign llu_ready = !reset && (llu_gnt || !llu_valid);

    always_comb begin
        rf_wr_en      = 1'b0;
        rf_rd         = '0;
        rf_write_data = '0;
        if (llu_gnt) begin
            rf_rd         = llu_rd;
            rf_write_data = llu_data;
            rf_wr_en      = (llu_rd != '0);
        end else if (wb_gnt) begin
            rf_rd         = wb_rd;
            rf_write_data = wb_data;
            rf_wr_en      = (wb_rd != '0);
        end
    end

    // Index 0 is skipped so x0 can never report busy.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        rd_busy  = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (iss_rs1 == REG_ADDR_WIDTH'(i)) rs1_busy = busy_q[i];
            if (iss_rs2 == REG_ADDR_WIDTH'(i)) rs2_busy = busy_q[i];
            if (iss_rd  == REG_ADDR_WIDTH'(i)) rd_busy  = busy_q[i];
        end
    end

`ifdef RF_WPORT_BYPASS_EN
    assign rs1_byp = llu_gnt && (llu_rd == iss_rs1);
    assign rs2_byp = llu_gnt && (llu_rd == iss_rs2);
`else
    assign rs1_byp = 1'b0;
    assign rs2_byp = 1'b0;
`endif

    assign iss_stall = !reset && iss_valid &&
                       ((rs1_busy && !rs1_byp) || (rs2_busy && !rs2_byp) || rd_busy);

    assign set_en = iss_valid && iss_long && !iss_stall && (iss_rd != '0);

    // Set is applied after clear so a newly issued op keeps ownership of its register.
    always_comb begin
        busy_nxt = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (llu_gnt && llu_rd == REG_ADDR_WIDTH'(i)) busy_nxt[i] = 1'b0;
            if (set_en && iss_rd == REG_ADDR_WIDTH'(i))  busy_nxt[i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            starve_cnt <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (!llu_valid || llu_gnt)
                starve_cnt <= '0;
            else if (!starved)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_wport_sched.sv
// Testbench for rf_wport_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_rf_wport_sched;

    localparam int MAX_STARVE = 4;
`ifdef RF_WPORT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, llu_valid, iss_valid, iss_long;
    logic [4:0]  wb_rd, llu_rd, iss_rd, iss_rs1, iss_rs2;
    logic [31:0] wb_data, llu_data;
    logic        wb_ready, llu_ready, iss_stall, rf_wr_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic [31:0] busy_vec;

    int n_vec = 0;
    int n_err = 0;

    rf_wport_sched #(.XLEN(32), .REG_ADDR_WIDTH(5), .NUM_REGS(32), .MAX_STARVE(MAX_STARVE)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data), .llu_ready(llu_ready),
        .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd), .iss_rs1(iss_rs1),
        .iss_rs2(iss_rs2), .iss_stall(iss_stall),
        .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_write_data(rf_write_data), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        llu_valid = 0; llu_rd = 0; llu_data = 0;
        iss_valid = 0; iss_long = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        wb_valid = 1; wb_rd = 3; wb_data = 32'h55;
        llu_valid = 1; llu_rd = 5; llu_data = 32'h66;
        iss_valid = 1; iss_long = 1; iss_rd = 4; iss_rs1 = 1; iss_rs2 = 2;
        next(); #1;
        n_vec++; if (wb_ready !== 1'b0) begin n_err++; $display("FAIL reset_wb_ready got %b exp 0", wb_ready); end
        n_vec++; if (llu_ready !== 1'b0) begin n_err++; $display("FAIL reset_llu_ready got %b exp 0", llu_ready); end
        n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b exp 0", rf_wr_en); end
        n_vec++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", iss_stall); end
        n_vec++; if (rf_rd !== 5'd0) begin n_err++; $display("FAIL reset_rf_rd got %0d exp 0", rf_rd); end
        n_vec++; if (rf_write_data !== 32'd0) begin n_err++; $display("FAIL reset_wdata got %h exp 0", rf_write_data); end
        n_vec++; if (busy_vec !== 32'd0) begin n_err++; $display("FAIL reset_busy got %h exp 0", busy_vec); end
        reset = 0; idle();
        next();
    endtask

    task automatic test_raw_hazard();
        iss_valid = 1; iss_long = 1; iss_rd = 5; iss_rs1 = 1; iss_rs2 = 2;
        #1;
        n_vec++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL raw_issue_long got %b exp 0", iss_stall); end
        next();
        iss_long = 0; iss_rd = 6; iss_rs1 = 5; iss_rs2 = 0;
        #1;
        n_vec++; if (busy_vec !== 32'h20) begin n_err++; $display("FAIL raw_busy_set got %h exp 20", busy_vec); end
        n_vec++; if (iss_stall !== 1'b1) begin n_err++; $display("FAIL raw_stall got %b exp 1", iss_stall); end
        next();
        llu_valid = 1; llu_rd = 5; llu_data = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (llu_ready !== 1'b1) begin n_err++; $display("FAIL raw_llu_ready got %b exp 1", llu_ready); end
        n_vec++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL raw_wr_en got %b exp 1", rf_wr_en); end
        n_vec++; if (rf_rd !== 5'd5) begin n_err++; $display("FAIL raw_rf_rd got %0d exp 5", rf_rd); end
        n_vec++; if (rf_write_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL raw_wdata got %h exp deadbeef", rf_write_data); end
        n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL raw_wb_idle_ready got %b exp 1", wb_ready); end
        n_vec++; if (iss_stall !== !BYP) begin n_err++; $display("FAIL raw_stall_on_return got %b exp %b", iss_stall, !BYP); end
        next();
        llu_valid = 0;
        #1;
        n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL raw_busy_clear got %h exp 0", busy_vec); end
        n_vec++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL raw_stall_after got %b exp 0", iss_stall); end
        idle();
        next();
    endtask

    task automatic test_starvation();
        bit lw;
        wb_valid = 1; wb_rd = 3; wb_data = 32'h0BAD_F00D;
        llu_valid = 1; llu_rd = 9; llu_data = 32'h1357_9BDF;
        for (int c = 0; c < 2 * MAX_STARVE + 2; c++) begin
            lw = (c == MAX_STARVE) || (c == 2 * MAX_STARVE + 1);
            #1;
            n_vec++; if (wb_ready !== !lw) begin n_err++; $display("FAIL starve_wb_ready c%0d got %b exp %b", c, wb_ready, !lw); end
            n_vec++; if (llu_ready !== lw) begin n_err++; $display("FAIL starve_llu_ready c%0d got %b exp %b", c, llu_ready, lw); end
            n_vec++; if (rf_rd !== (lw ? 5'd9 : 5'd3)) begin n_err++; $display("FAIL starve_rf_rd c%0d got %0d exp %0d", c, rf_rd, lw ? 9 : 3); end
            n_vec++; if (rf_write_data !== (lw ? 32'h1357_9BDF : 32'h0BAD_F00D)) begin n_err++; $display("FAIL starve_wdata c%0d got %h", c, rf_write_data); end
            next();
        end
        idle();
        next();
    endtask

    task automatic test_x0();
        wb_valid = 1; wb_rd = 0; wb_data = 32'h1234;
        #1;
        n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL x0_wb_ready got %b exp 1", wb_ready); end
        n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL x0_wr_en got %b exp 0", rf_wr_en); end
        next();
        idle();
        iss_valid = 1; iss_long = 1; iss_rd = 0; iss_rs1 = 3; iss_rs2 = 4;
        #1;
        n_vec++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL x0_long_stall got %b exp 0", iss_stall); end
        next();
        iss_long = 0; iss_rd = 1; iss_rs1 = 0; iss_rs2 = 0;
        #1;
        n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL x0_busy got %h exp 0", busy_vec); end
        n_vec++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL x0_rs_stall got %b exp 0", iss_stall); end
        idle();
        next();
    endtask

    task automatic test_set_clear_same();
        llu_valid = 1; llu_rd = 7; llu_data = 32'h7777;
        iss_valid = 1; iss_long = 1; iss_rd = 7; iss_rs1 = 1; iss_rs2 = 2;
        #1;
        n_vec++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL sc_stall got %b exp 0", iss_stall); end
        next();
        llu_valid = 0;
        #1;
        n_vec++; if (busy_vec !== 32'h80) begin n_err++; $display("FAIL sc_set_wins got %h exp 80", busy_vec); end
        n_vec++; if (iss_stall !== 1'b1) begin n_err++; $display("FAIL sc_waw_stall got %b exp 1", iss_stall); end
        next();
        iss_valid = 0; llu_valid = 1; llu_rd = 7;
        next();
        idle();
        #1;
        n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL sc_cleared got %h exp 0", busy_vec); end
        next();
    endtask

    task automatic test_reset_mid();
        iss_valid = 1; iss_long = 1; iss_rd = 5; iss_rs1 = 0; iss_rs2 = 0;
        next();
        iss_rd = 7;
        next();
        iss_valid = 0;
        #1;
        n_vec++; if (busy_vec !== 32'hA0) begin n_err++; $display("FAIL rm_busy_pre got %h exp a0", busy_vec); end
        reset = 1; llu_valid = 1; llu_rd = 5; llu_data = 32'hCAFE; wb_valid = 1; wb_rd = 2;
        iss_valid = 1; iss_long = 0; iss_rd = 7; iss_rs1 = 5;
        #1;
        n_vec++; if ({wb_ready, llu_ready, rf_wr_en, iss_stall} !== 4'b0) begin n_err++; $display("FAIL rm_outputs got %b exp 0000", {wb_ready, llu_ready, rf_wr_en, iss_stall}); end
        n_vec++; if (rf_write_data !== 32'd0) begin n_err++; $display("FAIL rm_wdata got %h exp 0", rf_write_data); end
        next();
        reset = 0; wb_valid = 0; iss_valid = 0;
        #1;
        n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL rm_busy_post got %h exp 0", busy_vec); end
        n_vec++; if (llu_ready !== 1'b1) begin n_err++; $display("FAIL rm_llu_ready got %b exp 1", llu_ready); end
        n_vec++; if (rf_wr_en !== 1'b1 || rf_rd !== 5'd5) begin n_err++; $display("FAIL rm_llu_write got en=%b rd=%0d exp en=1 rd=5", rf_wr_en, rf_rd); end
        next();
        idle();
        #1;
        n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL rm_busy_unchanged got %h exp 0", busy_vec); end
        next();
    endtask

    // Reference model: busy set of registers and count of consecutive LLU arbitration losses.
    task automatic test_random();
        bit          busy[32];
        int          losses;
        bit          g_llu, g_wb, e_wbr, e_llur, e_en, e_stall, h1, h2, waw;
        logic [4:0]  e_rd;
        logic [31:0] e_data, e_busy;
        bit          hold_wb, hold_llu;
        for (int i = 0; i < 32; i++) busy[i] = 0;
        losses = 0; hold_wb = 0; hold_llu = 0;
        reset = 1; idle();
        next();
        reset = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 59) == 0);
            if (!hold_wb) begin
                wb_valid = ($urandom_range(0, 2) != 0);
                wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            end
            if (!hold_llu) begin
                llu_valid = ($urandom_range(0, 1) != 0);
                llu_rd = 5'($urandom_range(0, 7)); llu_data = $urandom;
            end
            iss_valid = ($urandom_range(0, 3) != 0);
            iss_long = ($urandom_range(0, 1) != 0);
            iss_rd = 5'($urandom_range(0, 7));
            iss_rs1 = 5'($urandom_range(0, 7));
            iss_rs2 = 5'($urandom_range(0, 7));
            #1;
            e_busy = '0;
            for (int i = 1; i < 32; i++) e_busy[i] = busy[i];
            if (reset) begin
                g_llu = 0; g_wb = 0; e_wbr = 0; e_llur = 0; e_stall = 0;
            end else begin
                g_llu = llu_valid && (!wb_valid || losses == MAX_STARVE);
                g_wb = wb_valid && !g_llu;
                e_wbr = g_wb || !wb_valid;
                e_llur = g_llu || !llu_valid;
                h1 = iss_rs1 != 0 && busy[iss_rs1] && !(BYP && g_llu && llu_rd == iss_rs1);
                h2 = iss_rs2 != 0 && busy[iss_rs2] && !(BYP && g_llu && llu_rd == iss_rs2);
                waw = iss_rd != 0 && busy[iss_rd];
                e_stall = iss_valid && (h1 || h2 || waw);
            end
            e_rd = g_llu ? llu_rd : (g_wb ? wb_rd : 5'd0);
            e_data = g_llu ? llu_data : (g_wb ? wb_data : 32'd0);
            e_en = (g_llu || g_wb) && e_rd != 0;
            n_vec++; if (wb_ready !== e_wbr) begin n_err++; $display("FAIL rnd_wb_ready cyc%0d got %b exp %b", cyc, wb_ready, e_wbr); end
            n_vec++; if (llu_ready !== e_llur) begin n_err++; $display("FAIL rnd_llu_ready cyc%0d got %b exp %b", cyc, llu_ready, e_llur); end
            n_vec++; if (rf_wr_en !== e_en) begin n_err++; $display("FAIL rnd_wr_en cyc%0d got %b exp %b", cyc, rf_wr_en, e_en); end
            n_vec++; if (rf_rd !== e_rd) begin n_err++; $display("FAIL rnd_rf_rd cyc%0d got %0d exp %0d", cyc, rf_rd, e_rd); end
            n_vec++; if (rf_write_data !== e_data) begin n_err++; $display("FAIL rnd_wdata cyc%0d got %h exp %h", cyc, rf_write_data, e_data); end
            n_vec++; if (iss_stall !== e_stall) begin n_err++; $display("FAIL rnd_stall cyc%0d got %b exp %b", cyc, iss_stall, e_stall); end
            n_vec++; if (busy_vec !== e_busy) begin n_err++; $display("FAIL rnd_busy cyc%0d got %h exp %h", cyc, busy_vec, e_busy); end
            if (reset) begin
                for (int i = 0; i < 32; i++) busy[i] = 0;
                losses = 0;
            end else begin
                if (llu_valid && !g_llu) losses = (losses < MAX_STARVE) ? losses + 1 : MAX_STARVE;
                else losses = 0;
                if (g_llu) busy[llu_rd] = 0;
                if (iss_valid && iss_long && !e_stall && iss_rd != 0) busy[iss_rd] = 1;
            end
            hold_wb = wb_valid && !e_wbr;
            hold_llu = llu_valid && !e_llur;
            next();
        end
        reset = 0; idle();
        next();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_raw_hazard();
        test_starvation();
        test_x0();
        test_set_clear_same();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wport_sched.md
Name: rf_wport_sched

Overview:
- Schedules the single register-file write port between two writers:
  - the in-order pipeline writeback stage (WB);
  - the long-latency unit (LLU: divider / multi-cycle load return).
- Keeps a per-register busy scoreboard for in-flight LLU destinations and stalls issue on RAW and WAW hazards against them.
- Sits between WB/LLU and the regfile write port (rd, write_data, wr_en), and beside the issue stage.

Parameters:
- XLEN, 32, data width
- REG_ADDR_WIDTH, 5, register index width
- NUM_REGS, 32, architectural registers; x0 hardwired zero
- MAX_STARVE, 4, consecutive cycles LLU may lose arbitration before it is forced to win; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  WB has a result
- wb_rd  in  REG_ADDR_WIDTH  WB destination
- wb_data  in  XLEN  WB result
- wb_ready  out  1  WB result accepted this cycle; when 0, WB holds its inputs
- llu_valid  in  1  LLU has a result
- llu_rd  in  REG_ADDR_WIDTH  LLU destination
- llu_data  in  XLEN  LLU result
- llu_ready  out  1  LLU result accepted this cycle
- iss_valid  in  1  issue stage presents an instruction
- iss_long  in  1  instruction goes to LLU
- iss_rd, iss_rs1, iss_rs2  in  REG_ADDR_WIDTH each  instruction register fields
- iss_stall  out  1  hold issue this cycle
- rf_wr_en  out  1  regfile write enable
- rf_rd  out  REG_ADDR_WIDTH  regfile write address
- rf_write_data  out  XLEN  regfile write data
- busy_vec  out  NUM_REGS  scoreboard state; bit 0 always 0

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous, active-high.
- While reset is high:
  - wb_ready, llu_ready, rf_wr_en and iss_stall are 0.
  - busy_vec clears to 0 at the next edge.
  - starve_cnt clears to 0 at the next edge.
  - rf_rd = 0 and rf_write_data = 0.
- Reset mid-operation discards pending busy bits. An LLU result arriving after reset is accepted normally and clears nothing.
- Arbitration is combinational with zero-cycle grant. The regfile commits at the same clk edge.
  - Only WB valid: grant WB.
  - Only LLU valid: grant LLU.
  - Both valid and starve_cnt < MAX_STARVE: grant WB; llu_ready = 0.
  - Both valid and starve_cnt == MAX_STARVE: grant LLU; wb_ready = 0.
  - Neither valid: no grant; rf_wr_en = 0, rf_rd = 0, rf_write_data = 0.
- Ready outputs: a requester's ready = 1 when granted, and also when idle (ready may be high without valid).
- Write-port drive: rf_rd / rf_write_data come from the winner. rf_wr_en = grant && winner rd != 0.
  - A grant with rd == 0 still completes the handshake but does not write.
- starve_cnt is 4 bits:
  - increments when llu_valid && !llu_ready;
  - clears when the LLU is granted or llu_valid = 0;
  - saturates at MAX_STARVE.
- Scoreboard set: busy[iss_rd] sets at the edge when iss_valid && iss_long && !iss_stall && iss_rd != 0.
- Scoreboard clear: busy[llu_rd] clears at the edge when llu_valid && llu_ready.
- Set and clear of the same register in the same cycle: set wins (the new op owns the register).
- Stall rule: iss_stall = iss_valid && (hazard on rs1 || hazard on rs2 || busy[iss_rd]).
  - The busy[iss_rd] term (WAW) applies to long and short ops alike.
  - Index 0 never hazards.
- Hazard on rs1 / rs2: busy[rsN] = 1 and not bypassed (see Optional Feature).
- LLU precondition: an LLU result for a non-busy register is legal (for example after reset) and clears nothing.
- Latency:
  - Grant: 0 cycles.
  - Scoreboard update: visible the cycle after the handshake edge.

Optional Feature:
- Macro: RF_WPORT_BYPASS_EN.
- Defined: a rs1 or rs2 hazard is suppressed when the LLU is granted this cycle with llu_rd equal to that source. The source value is picked up from the regfile's same-cycle write-data forwarding, so issue proceeds in the same cycle.
- Not defined: stall persists until busy[] clears at the edge; issue proceeds one cycle later.
- The WAW term on iss_rd is never bypassed.

Test Plan:
- Issue long op rd=5, then an op with rs1=5 → busy_vec[5]=1 and iss_stall=1. When LLU returns rd=5, data=0xDEAD_BEEF, llu_ready=1, rf_wr_en=1, rf_rd=5. Stall drops the same cycle with RF_WPORT_BYPASS_EN, one cycle later without it.
- wb_valid and llu_valid held high for 8 cycles with MAX_STARVE=4 → WB granted on cycles 0-3, LLU on cycle 4 (wb_ready=0), WB thereafter; starve_cnt returns to 0.
- WB writes rd=0, data=0x1234 → wb_ready=1, rf_wr_en=0.
- Long issue rd=0 → busy_vec stays 0, no stall on a later rs1=0.
- Same cycle: LLU completes rd=7 while a new long op issues rd=7 → busy_vec[7]=1 after the edge. A further long issue with rd=7 → iss_stall=1 (WAW).
- Assert reset with busy_vec=0x0000_00A0 and llu_valid=1 → outputs 0 during reset, busy_vec=0 after. An LLU result for rd=5 then writes normally with no scoreboard change.
